trace_tx: RTL and testbench

//  TPIU-style trace port transmitter: serialises 128-bit formatted frames onto a 1/2/4-bit DDR TRACEDATA
//  bus clocked by traceClkin. Inserts full sync (0x7FFF_FFFF) after reset and periodically, and

---
 rtl/trace_tx.sv | 168 ++++++++++++++++
 tb/tb_trace_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_tx.sv
// Trace port transmitter: serialises 128-bit frames as 16-bit halfwords onto a 1/2/4-bit DDR bus.
// Full syncs (FFFF,7FFF) go out after reset, periodically and on width change; 7FFF pads fill idle time.
module trace_tx #(
  parameter int MAXBUSWIDTH   = 4,
  parameter int SYNC_INTERVAL = 16
) (
  input  logic                   traceClkin,
  input  logic                   rst,
  input  logic [1:0]             width,
  input  logic [127:0]           packet,
  input  logic                   pkValid,
  output logic                   pkReady,
  output logic [MAXBUSWIDTH-1:0] traceDouta,
  output logic [MAXBUSWIDTH-1:0] traceDoutb,
  output logic                   syncSent,
  output logic                   frameSent
);

  localparam int NB = (MAXBUSWIDTH < 4) ? MAXBUSWIDTH : 4;
  localparam logic [7:0] SI = 8'(SYNC_INTERVAL);

  typedef enum logic [1:0] {SYNC0, SYNC1, IDLE, DATA} state_t;

  state_t         state, state_nx;
  logic [15:0]    sr, hw;
  logic [2:0]     cnt, idx, idx_nx;
  logic [1:0]     cw;
  logic           run, buf_full, buf_full_nx, sync_pend, sync_pend_nx;
  logic [127:0]   hold, frame, fsh;
  logic [7:0]     frame_cnt, frame_cnt_nx;
  logic           bnd, wchg, pend_eff, accept, load, sync_tog, frame_tog;
  logic [7:0]     ba_nx;
  logic [MAXBUSWIDTH-1:0] a_w, b_w;

  function automatic logic [2:0] last_beat(input logic [1:0] w);
    case (w)
      2'd3:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // Returns {b, a} for beat k of halfword d at bus width w; LSBs go out first.
  function automatic logic [7:0] beat_bits(input logic [15:0] d, input logic [1:0] w,
                                           input logic [2:0] k);
    logic [15:0] s;
    case (w)
      2'd3: begin
        s = d >> {k, 3'b000};
        return {s[7:4], s[3:0]};
      end
      2'd2: begin
        s = d >> {k, 2'b00};
        return {2'b00, s[3:2], 2'b00, s[1:0]};
      end
      default: begin
        s = d >> {k, 1'b0};
        return {3'b000, s[1], 3'b000, s[0]};
      end
    endcase
  endfunction

  always_comb begin
    bnd          = !run || (cnt == last_beat(cw));
    wchg         = run && (width != cw);
    pend_eff     = sync_pend || wchg;
    accept       = pkValid && pkReady;
    fsh          = frame >> {idx, 4'b0000};
    state_nx     = state;
    hw           = 16'h7FFF;
    idx_nx       = idx;
    sync_pend_nx = sync_pend;
    frame_cnt_nx = frame_cnt;
    load         = 1'b0;
    sync_tog     = 1'b0;
    frame_tog    = 1'b0;
    if (bnd) begin
      if (wchg) sync_pend_nx = 1'b1;
      case (state)
        SYNC0: begin
          hw       = 16'hFFFF;
          state_nx = SYNC1;
        end
        SYNC1: begin
          sync_tog     = 1'b1;
          sync_pend_nx = wchg;
          state_nx     = IDLE;
        end
        IDLE: begin
          if (pend_eff) begin
            hw       = 16'hFFFF;
            state_nx = SYNC1;
          end else if (buf_full) begin
            load     = 1'b1;
            hw       = hold[15:0];
            idx_nx   = 3'd1;
            state_nx = DATA;
          end
        end
        DATA: begin
          hw     = fsh[15:0];
          idx_nx = idx + 3'd1;
          if (idx == 3'd7) begin
            frame_tog = 1'b1;
            state_nx  = IDLE;
            // Periodic sync is only scheduled here, so it always lands between frames.
            if (SI != 8'd0 && (frame_cnt + 8'd1) == SI) begin
              frame_cnt_nx = 8'd0;
              sync_pend_nx = 1'b1;
            end else begin
              frame_cnt_nx = frame_cnt + 8'd1;
            end
          end
        end
        default: state_nx = SYNC0;
      endcase
    end
    buf_full_nx = accept ? 1'b1 : (load ? 1'b0 : buf_full);
    ba_nx = bnd ? beat_bits(hw, width, 3'd0) : beat_bits(sr, cw, cnt + 3'd1);
    a_w = '0;
    b_w = '0;
    a_w[NB-1:0] = ba_nx[NB-1:0];
    b_w[NB-1:0] = ba_nx[NB+3:4];
  end

  always_ff @(posedge traceClkin or posedge rst) begin
    if (rst) begin
      state      <= SYNC0;
      sr         <= '0;
      cnt        <= '0;
      idx        <= '0;
      cw         <= '0;
      run        <= 1'b0;
      buf_full   <= 1'b0;
      sync_pend  <= 1'b1;
      hold       <= '0;
      frame      <= '0;
      frame_cnt  <= '0;
      pkReady    <= 1'b0;
      traceDouta <= '0;
      traceDoutb <= '0;
      syncSent   <= 1'b0;
      frameSent  <= 1'b0;
    end else begin
      run        <= 1'b1;
      state      <= state_nx;
      idx        <= idx_nx;
      sync_pend  <= sync_pend_nx;
      frame_cnt  <= frame_cnt_nx;
      buf_full   <= buf_full_nx;
      pkReady    <= !buf_full_nx;
      traceDouta <= a_w;
      traceDoutb <= b_w;
      syncSent   <= syncSent ^ sync_tog;
      frameSent  <= frameSent ^ frame_tog;
      if (accept) hold <= packet;
      if (load)   frame <= hold;
      if (bnd) begin
        sr  <= hw;
        cw  <= width;
        cnt <= 3'd0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_trace_tx.sv
// Directed bench for trace_tx: beat-by-beat check of syncs, pads, frames, width changes and reset abort.
module tb_trace_tx;

  logic         traceClkin = 1'b0;
  logic         rst;
  logic [1:0]   width;
  logic [127:0] packet;
  logic         pkValid;
  logic         pkReady;
  logic [3:0]   traceDouta, traceDoutb;
  logic         syncSent, frameSent;

  int vectors = 0;
  int miscompares = 0;
  logic exp_ss = 1'b0;
  logic exp_fs = 1'b0;
  logic [127:0] feed[$];

  localparam logic [127:0] FA = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [127:0] FB = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] FC = 128'hA5A5_5A5A_C3C3_3C3C_0110_1001_8421_1248;
  localparam logic [127:0] FD = 128'h0BAD_F00D_CAFE_BEEF_1357_2468_ACE0_BDF1;
  localparam logic [127:0] FE = 128'h3210_7654_BA98_FEDC_0001_0100_1000_0010;
  localparam logic [127:0] FF = 128'h5555_AAAA_6666_9999_1111_2222_4444_8888;
  localparam logic [127:0] FG = 128'hE1D2_C3B4_A596_8778_6950_4A3B_2C1D_0E0F;
  localparam logic [127:0] FH = 128'h0F0F_F0F0_3333_CCCC_1A2B_3C4D_5E6F_7081;

  trace_tx #(.MAXBUSWIDTH(4), .SYNC_INTERVAL(2)) dut (
    .traceClkin(traceClkin),
    .rst       (rst),
    .width     (width),
    .packet    (packet),
    .pkValid   (pkValid),
    .pkReady   (pkReady),
    .traceDouta(traceDouta),
    .traceDoutb(traceDoutb),
    .syncSent  (syncSent),
    .frameSent (frameSent)
  );

  always #5 traceClkin = ~traceClkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_next();
    if (feed.size() > 0) begin
      pkValid = 1'b1;
      packet  = feed.pop_front();
    end else begin
      pkValid = 1'b0;
    end
  endtask

  // One clock: advance the feeder on acceptance, then compare the beat on the bus.
  task automatic beat(input logic [3:0] ea, input logic [3:0] eb, input string tag);
    logic r;
    r = pkReady;
    @(posedge traceClkin);
    #1;
    if (pkValid && r) load_next();
    chk(tag, {24'd0, traceDouta, traceDoutb}, {24'd0, ea, eb});
  endtask

  task automatic hw_chk(input logic [15:0] hwd, input logic [1:0] w, input string tag);
    logic [15:0] h;
    int n;
    h = hwd;
    n = (w == 2'd3) ? 2 : (w == 2'd2) ? 4 : 8;
    for (int k = 0; k < n; k++) begin
      case (w)
        2'd3: begin beat(h[3:0], h[7:4], tag); h = h >> 8; end
        2'd2: begin beat({2'b00, h[1:0]}, {2'b00, h[3:2]}, tag); h = h >> 4; end
        default: begin beat({3'b000, h[0]}, {3'b000, h[1]}, tag); h = h >> 2; end
      endcase
    end
  endtask

  task automatic send_sync(input logic [1:0] w, input string tag);
    hw_chk(16'hFFFF, w, {tag, "_sync0"});
    hw_chk(16'h7FFF, w, {tag, "_sync1"});
    exp_ss = ~exp_ss;
    chk({tag, "_syncSent"}, {31'd0, syncSent}, {31'd0, exp_ss});
  endtask

  task automatic send_frame(input logic [127:0] p, input logic [1:0] w, input int first,
                            input string tag);
    logic [127:0] s;
    s = p >> (16 * first);
    for (int i = first; i < 8; i++) begin
      hw_chk(s[15:0], w, $sformatf("%s_hw%0d", tag, i));
      s = s >> 16;
    end
    exp_fs = ~exp_fs;
    chk({tag, "_frameSent"}, {31'd0, frameSent}, {31'd0, exp_fs});
  endtask

  initial begin
    rst = 1'b1; width = 2'd3; packet = '0; pkValid = 1'b0;
    repeat (2) @(posedge traceClkin);
    #1;
    chk("rst_a", {28'd0, traceDouta}, 32'd0);
    chk("rst_b", {28'd0, traceDoutb}, 32'd0);
    chk("rst_pkReady", {31'd0, pkReady}, 32'd0);
    chk("rst_syncSent", {31'd0, syncSent}, 32'd0);
    chk("rst_frameSent", {31'd0, frameSent}, 32'd0);
    rst = 1'b0;

    // Post-reset full sync and idle pads at 4-bit width, literal beats.
    beat(4'hF, 4'hF, "t1_b0");
    chk("t1_pkReady", {31'd0, pkReady}, 32'd1);
    beat(4'hF, 4'hF, "t1_b1");
    beat(4'hF, 4'hF, "t1_b2");
    beat(4'hF, 4'h7, "t1_b3");
    exp_ss = 1'b1;
    chk("t1_syncSent", {31'd0, syncSent}, 32'd1);
    beat(4'hF, 4'hF, "t1_pad0");
    beat(4'hF, 4'h7, "t1_pad1");

    // Single frame, 4-bit width.
    feed.push_back(FA);
    load_next();
    beat(4'hF, 4'hF, "t2_pad0");
    chk("t2_pkReady_drop", {31'd0, pkReady}, 32'd0);
    beat(4'hF, 4'h7, "t2_pad1");
    beat(4'h1, 4'h0, "t2_hw0_b0");
    chk("t2_pkReady_back", {31'd0, pkReady}, 32'd1);
    beat(4'h0, 4'h0, "t2_hw0_b1");
    beat(4'h2, 4'h0, "t2_hw1_b0");
    beat(4'h0, 4'h0, "t2_hw1_b1");
    send_frame(FA, 2'd3, 2, "t2");
    hw_chk(16'h7FFF, 2'd3, "t2_pad");

    // Back-to-back frames with SYNC_INTERVAL=2 (FA was frame 1).
    feed.push_back(FB); feed.push_back(FC); feed.push_back(FD); feed.push_back(FE);
    load_next();
    hw_chk(16'h7FFF, 2'd3, "t4_pad");
    send_frame(FB, 2'd3, 0, "t4_B");
    send_sync(2'd3, "t4_s1");
    send_frame(FC, 2'd3, 0, "t4_C");
    send_frame(FD, 2'd3, 0, "t4_D");
    send_sync(2'd3, "t4_s2");
    send_frame(FE, 2'd3, 0, "t4_E");
    hw_chk(16'h7FFF, 2'd3, "t4_tail");
    chk("t4_pkValid_drained", {31'd0, pkValid}, 32'd0);

    // Reset during halfword 3 of a frame.
    feed.push_back(FF);
    load_next();
    hw_chk(16'h7FFF, 2'd3, "t5_pad");
    hw_chk(FF[15:0], 2'd3, "t5_hw0");
    hw_chk(FF[31:16], 2'd3, "t5_hw1");
    hw_chk(FF[47:32], 2'd3, "t5_hw2");
    rst = 1'b1;
    #1;
    chk("t5_rst_ab", {24'd0, traceDouta, traceDoutb}, 32'd0);
    chk("t5_rst_pkReady", {31'd0, pkReady}, 32'd0);
    exp_ss = 1'b0;
    exp_fs = 1'b0;
    repeat (2) @(posedge traceClkin);
    #1;
    chk("t5_rst_hold_ab", {24'd0, traceDouta, traceDoutb}, 32'd0);
    chk("t5_rst_frameSent", {31'd0, frameSent}, 32'd0);
    rst = 1'b0;
    send_sync(2'd3, "t5_resync");
    hw_chk(16'h7FFF, 2'd3, "t5_pad_after");
    hw_chk(16'h7FFF, 2'd3, "t5_pad_after2");
    chk("t5_frameSent_kept", {31'd0, frameSent}, 32'd0);

    // Width 3->2 with a frame buffered: sync at new width first.
    width = 2'd2;
    feed.push_back(FG);
    load_next();
    send_sync(2'd2, "t6_w2");
    send_frame(FG, 2'd2, 0, "t6_G");
    hw_chk(16'h7FFF, 2'd2, "t6_pad");

    // Width 2->0; second frame since reset also triggers a periodic sync.
    width = 2'd0;
    feed.push_back(FH);
    load_next();
    send_sync(2'd0, "t3_w0");
    send_frame(FH, 2'd0, 0, "t3_H");
    send_sync(2'd0, "t3_periodic");
    hw_chk(16'h7FFF, 2'd0, "t3_pad");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
